// File: rtl/shift_tap_pkg.sv
// Shared constants and types for the 8x64 tapped shift-register controller.
//   DATA_W     : byte width of the shift-register input and request data
//   DEPTH      : register depth, which is also the sr_out position
//   TAP1..TAP3 : tap positions that are flagged valid once filled
//   FLUSH_VAL  : byte shifted into every position during a flush
//   fill_cnt_t : fill-depth counter, wide enough to hold DEPTH itself
package shift_tap_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
  localparam int TAP1   = 16;
  localparam int TAP2   = 32;
  localparam int TAP3   = 48;

  localparam logic [DATA_W-1:0] FLUSH_VAL = 8'h00;

  localparam int FILL_W  = $clog2(DEPTH + 1);
  localparam int FLUSH_W = $clog2(DEPTH);

  typedef logic [FILL_W-1:0] fill_cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sr_ctrl_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n     : clock and asynchronous active-low reset
//   valid0, valid1 : request lines from the two streams
//   fire           : a transfer completed this cycle for the granted stream
//   grant          : stream index currently granted (combinational)
// A lone requester always wins; with both requesting, the stream that did
// not win the previous transfer wins. With nobody requesting the grant
// still points at the "next in turn" stream so its ready can be high early.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic fire,
  output logic grant
);

  // Resets to 1 so stream 0 is the first winner under contention.
  logic last_grant_reg;

  always_comb begin
    grant = ~last_grant_reg;
    if (valid0 && !valid1) begin
      grant = 1'b0;
    end else if (valid1 && !valid0) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
    end else if (fire) begin
      last_grant_reg <= grant;
    end
  end

endmodule

// File: rtl/shift_8x64_tap_ctrl.sv
// Sequencer and arbiter for the 8x64 tapped shift register.
// Merges two valid/ready byte streams onto the register's shift/sr_in port,
// tracks how many valid bytes the register holds and runs a flush that
// overwrites every position with FLUSH_VAL.
//   clk, rst_n              : clock, asynchronous active-low reset
//   enable                  : accept stream data (RUN) or go back to IDLE
//   flush                   : one-cycle request to start a flush
//   req0_* / req1_*         : valid/ready byte streams
//   sr_shift, sr_in         : drive the shift register
//   grant_id                : stream shifted this cycle (only with a data fire)
//   fill_cnt                : valid bytes held, saturating at DEPTH
//   tap1/2/3_vld, out_vld   : tap / output positions hold valid data
//   busy                    : flush in progress
module shift_8x64_tap_ctrl
  import shift_tap_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              sr_shift,
  output logic [DATA_W-1:0] sr_in,
  output logic              grant_id,
  output logic [FILL_W-1:0] fill_cnt,
  output logic              tap1_vld,
  output logic              tap2_vld,
  output logic              tap3_vld,
  output logic              out_vld,
  output logic              busy
);

  sr_ctrl_state_t     state_reg;
  logic [FLUSH_W-1:0] flush_cnt_reg;
  fill_cnt_t          fill_cnt_reg;
  logic [DATA_W-1:0]  sr_in_reg;

  logic grant;
  logic fire;
  logic run;

  assign run  = (state_reg == RUN);
  assign busy = (state_reg == FLUSH);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .fire   (fire),
    .grant  (grant)
  );

  // A pending flush masks both readies so a data fire can never share a
  // cycle with the flush start.
  assign req0_ready = run && !flush && !grant;
  assign req1_ready = run && !flush &&  grant;
  assign fire       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sr_shift = fire || busy;
  assign grant_id = fire && grant;

  // Between shifts sr_in holds the last byte actually shifted.
  always_comb begin
    sr_in = sr_in_reg;
    if (busy) begin
      sr_in = FLUSH_VAL;
    end else if (fire) begin
      sr_in = grant ? req1_data : req0_data;
    end
  end

  assign fill_cnt = fill_cnt_reg;
  assign tap1_vld = (fill_cnt_reg >= fill_cnt_t'(TAP1));
  assign tap2_vld = (fill_cnt_reg >= fill_cnt_t'(TAP2));
  assign tap3_vld = (fill_cnt_reg >= fill_cnt_t'(TAP3));
  assign out_vld  = (fill_cnt_reg == fill_cnt_t'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      flush_cnt_reg <= '0;
      fill_cnt_reg  <= '0;
      sr_in_reg     <= '0;
    end else begin
      if (sr_shift) begin
        sr_in_reg <= sr_in;
      end
      case (state_reg)
        IDLE: begin
          if (flush) begin
            state_reg     <= FLUSH;
            fill_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
          end else if (enable) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            state_reg     <= FLUSH;
            fill_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
          end else begin
            if (!enable) begin
              state_reg <= IDLE;
            end
            if (fire && (fill_cnt_reg != fill_cnt_t'(DEPTH))) begin
              fill_cnt_reg <= fill_cnt_reg + 1'b1;
            end
          end
        end
        FLUSH: begin
          // flush/enable are only looked at once all DEPTH shifts are done.
          if (flush_cnt_reg == FLUSH_W'(DEPTH - 1)) begin
            state_reg     <= enable ? RUN : IDLE;
            flush_cnt_reg <= '0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_8x64_tap_ctrl.sv
// Directed self-checking bench for shift_8x64_tap_ctrl.
// Inputs change just after the falling edge; outputs are sampled 1 time
// unit later, well away from the rising edge that commits state.
module tb_shift_8x64_tap_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       flush;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       sr_shift;
  logic [7:0] sr_in;
  logic       grant_id;
  logic [6:0] fill_cnt;
  logic       tap1_vld;
  logic       tap2_vld;
  logic       tap3_vld;
  logic       out_vld;
  logic       busy;

  int checks = 0;
  int errors = 0;

  shift_8x64_tap_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .sr_shift   (sr_shift),
    .sr_in      (sr_in),
    .grant_id   (grant_id),
    .fill_cnt   (fill_cnt),
    .tap1_vld   (tap1_vld),
    .tap2_vld   (tap2_vld),
    .tap3_vld   (tap3_vld),
    .out_vld    (out_vld),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus, then settle before sampling.
  task automatic step(input logic fl, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1);
    @(negedge clk);
    flush      = fl;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    flush      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    int n1;
    logic [7:0] exp_b;
    int exp_fill;

    rst_n      = 1'b1;
    enable     = 1'b0;
    flush      = 1'b0;
    req0_valid = 1'b0;
    req0_data  = 8'h00;
    req1_valid = 1'b0;
    req1_data  = 8'h00;

    // ---------------- reset state ----------------
    #2 rst_n = 1'b0;
    #1;
    chk("rst_fill", fill_cnt, 0);
    chk("rst_flags", {tap1_vld, tap2_vld, tap3_vld, out_vld, busy}, 0);
    chk("rst_shift", sr_shift, 0);
    chk("rst_sr_in", sr_in, 0);
    chk("rst_ready", {req0_ready, req1_ready, grant_id}, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // ---------------- test 1: 16 bytes from stream 0 ----------------
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i + 1), 1'b0, 8'h00);
      chk("t1_shift", sr_shift, 1);
      chk("t1_sr_in", sr_in, i + 1);
      chk("t1_grant", grant_id, 0);
      if (i == 15) chk("t1_tap1_before", tap1_vld, 0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("t1_fill", fill_cnt, 16);
    chk("t1_tap1", tap1_vld, 1);
    chk("t1_tap2", tap2_vld, 0);
    chk("t1_idle_shift", sr_shift, 0);
    chk("t1_hold_sr_in", sr_in, 8'h10);
    chk("t1_ready_no_valid", {req0_ready, req1_ready}, 2'b01);
    $display("test1 stream0 16 bytes: fill=%0d tap1=%0b tap2=%0b", fill_cnt, tap1_vld, tap2_vld);

    // ---------------- test 2: both streams, round robin ----------------
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'(8'hA0 + n0), 1'b1, 8'(8'hB0 + n1));
      exp_b = (i % 2 == 1) ? 8'(8'hB0 + i / 2) : 8'(8'hA0 + i / 2);
      chk("t2_grant", grant_id, i % 2);
      chk("t2_sr_in", sr_in, exp_b);
      chk("t2_shift", sr_shift, 1);
      if (req0_ready) n0++;
      if (req1_ready) n1++;
    end
    chk("t2_fires0", n0, 4);
    chk("t2_fires1", n1, 4);
    $display("test2 round robin: fires0=%0d fires1=%0d", n0, n1);

    // ---------------- test 3: saturation after 70 fires ----------------
    do_reset();
    for (int k = 1; k <= 70; k++) begin
      step(1'b0, 1'b1, 8'(k), 1'b0, 8'h00);
      exp_fill = (k - 1 > 64) ? 64 : k - 1;
      chk("t3_fill", fill_cnt, exp_fill);
      chk("t3_out_vld", out_vld, (k - 1 >= 64) ? 1 : 0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("t3_fill_sat", fill_cnt, 64);
    chk("t3_flags", {tap1_vld, tap2_vld, tap3_vld, out_vld}, 4'b1111);
    $display("test3 saturation: fill=%0d out_vld=%0b", fill_cnt, out_vld);

    // ---------------- test 4: flush from RUN at fill 40 ----------------
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
    end
    step(1'b1, 1'b1, 8'h55, 1'b0, 8'h00);
    chk("t4_fill40", fill_cnt, 40);
    chk("t4_flush_no_ready", req0_ready, 0);
    chk("t4_flush_no_fire", sr_shift, 0);
    n0 = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b1, 8'h77, 1'b0, 8'h00);
      chk("t4_busy", busy, 1);
      chk("t4_shift", sr_shift, 1);
      chk("t4_sr_in", sr_in, 8'h00);
      chk("t4_ready", {req0_ready, req1_ready}, 0);
      chk("t4_fill0", fill_cnt, 0);
      if (busy) n0++;
    end
    step(1'b0, 1'b1, 8'h77, 1'b0, 8'h00);
    chk("t4_busy_done", busy, 0);
    chk("t4_resume_fire", sr_shift, 1);
    chk("t4_resume_data", sr_in, 8'h77);
    chk("t4_fill_after", fill_cnt, 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("t4_fill_one", fill_cnt, 1);
    $display("test4 flush: busy_cycles=%0d fill=%0d", n0, fill_cnt);

    // ---------------- test 5: enable drops during flush ----------------
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("t5_start_no_fire", sr_shift, 0);
    for (int i = 0; i < 64; i++) begin
      if (i == 10) enable = 1'b0;
      step((i == 20), 1'b0, 8'h00, 1'b0, 8'h00);
      chk("t5_busy", busy, 1);
      chk("t5_shift", sr_shift, 1);
    end
    step(1'b0, 1'b1, 8'h11, 1'b1, 8'h22);
    chk("t5_busy_done", busy, 0);
    chk("t5_idle_ready", {req0_ready, req1_ready}, 0);
    chk("t5_idle_shift", sr_shift, 0);
    step(1'b0, 1'b1, 8'h11, 1'b1, 8'h22);
    chk("t5_idle_ready2", {req0_ready, req1_ready}, 0);
    chk("t5_hold_sr_in", sr_in, 8'h00);
    chk("t5_fill", fill_cnt, 0);
    $display("test5 flush with enable low: busy=%0b ready0=%0b ready1=%0b", busy, req0_ready, req1_ready);

    // ---------------- test 6: async reset mid-stream ----------------
    enable = 1'b1;
    do_reset();
    for (int i = 0; i < 33; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
    end
    step(1'b0, 1'b1, 8'hC3, 1'b0, 8'h00);
    chk("t6_fill33", fill_cnt, 33);
    chk("t6_tap2", tap2_vld, 1);
    chk("t6_firing", sr_shift, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_fill_async", fill_cnt, 0);
    chk("t6_taps_async", {tap1_vld, tap2_vld, tap3_vld, out_vld}, 0);
    chk("t6_shift_async", sr_shift, 0);
    chk("t6_ready_async", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 8'h5A, 1'b1, 8'hA5);
    chk("t6_first_grant", grant_id, 0);
    chk("t6_first_data", sr_in, 8'h5A);
    chk("t6_ready1_low", req1_ready, 0);
    $display("test6 async reset: grant_id=%0b sr_in=0x%0h", grant_id, sr_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
